// File: rtl/jtag_dp_responder.sv
// Target-side JTAG-DP responder: oversampled TAP with IDCODE/BYPASS/DPACC/APACC.
// Optional ABORT DR (IR 4'b1000) is compiled in when JTAG_DP_ABORT_EN is defined.
module jtag_dp_responder #(
  parameter logic [31:0] IDCODE_VAL  = 32'h4BA00477,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  output logic        req,
  output logic        rnw,
  output logic        apndp,
  output logic [1:0]  addr32,
  output logic [31:0] dwrite,
  input  logic        done,
  input  logic        fault,
  input  logic [31:0] dread,
  output logic        busy
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_ACC, DR_ABORT} dr_sel_e;

  localparam logic [3:0]  IR_DPACC   = 4'b1010;
  localparam logic [3:0]  IR_APACC   = 4'b1011;
  localparam logic [3:0]  IR_IDCODE  = 4'b1110;
  localparam logic [34:0] RESULT_RST = {32'h0, 3'b010};
  localparam logic [34:0] ACK_WAIT   = {32'h0, 3'b001};
`ifdef JTAG_DP_ABORT_EN
  localparam logic [3:0]  IR_ABORT   = 4'b1000;
`endif

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic tck_prev, tck_s, tms_s, tdi_s, rise, fall;

  tap_state_e  state;
  dr_sel_e     dr_sel;
  logic [3:0]  ir, ir_sr;
  logic [34:0] dr_sr, result;
  logic        sticky_fault;
  logic        unused_sticky_fault;

  assign tck_s = tck_sync[SYNC_STAGES-1];
  assign tms_s = tms_sync[SYNC_STAGES-1];
  assign tdi_s = tdi_sync[SYNC_STAGES-1];
  assign rise  = tck_s & ~tck_prev;
  assign fall  = ~tck_s & tck_prev;

  // Fault is kept for a future CTRL/STAT view; it never alters the ack.
  assign unused_sticky_fault = sticky_fault;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic m);
    case (s)
      TLR:      return m ? TLR      : RTI;
      RTI:      return m ? SEL_DR   : RTI;
      SEL_DR:   return m ? SEL_IR   : CAP_DR;
      CAP_DR:   return m ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: return m ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: return m ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return m ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: return m ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return m ? SEL_DR   : RTI;
      SEL_IR:   return m ? TLR      : CAP_IR;
      CAP_IR:   return m ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: return m ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: return m ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return m ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: return m ? UPD_IR   : SHIFT_IR;
      UPD_IR:   return m ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir)
      IR_DPACC, IR_APACC: dr_sel = DR_ACC;
      IR_IDCODE:          dr_sel = DR_IDCODE;
`ifdef JTAG_DP_ABORT_EN
      IR_ABORT:           dr_sel = DR_ABORT;
`endif
      default:            dr_sel = DR_BYPASS;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      tck_prev <= tck_s;
    end
  end

  // NOTE: the shift registers are plain flops, so they are reset along with the rest of the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= TLR;
      ir           <= IR_IDCODE;
      ir_sr        <= '0;
      dr_sr        <= '0;
      tdo          <= 1'b1;
      req          <= 1'b0;
      busy         <= 1'b0;
      rnw          <= 1'b0;
      apndp        <= 1'b0;
      addr32       <= '0;
      dwrite       <= '0;
      result       <= RESULT_RST;
      sticky_fault <= 1'b0;
    end else begin
      req <= 1'b0;
      if (done && busy) begin
        result       <= {dread, 3'b010};
        sticky_fault <= sticky_fault | fault;
        busy         <= 1'b0;
      end
      if (rise) begin
        state <= tap_next(state, tms_s);
        case (state)
          CAP_IR:   ir_sr <= 4'b0001;
          SHIFT_IR: ir_sr <= {tdi_s, ir_sr[3:1]};
          UPD_IR:   ir    <= ir_sr;
          CAP_DR: begin
            case (dr_sel)
              DR_IDCODE: dr_sr <= {3'b000, IDCODE_VAL};
              DR_ACC:    dr_sr <= busy ? ACK_WAIT : result;
              default:   dr_sr <= '0;
            endcase
          end
          SHIFT_DR: begin
            // Each instruction has its own length; tdi enters at that length's MSB.
            case (dr_sel)
              DR_IDCODE: dr_sr[31:0] <= {tdi_s, dr_sr[31:1]};
              DR_BYPASS: dr_sr[0]    <= tdi_s;
              default:   dr_sr       <= {tdi_s, dr_sr[34:1]};
            endcase
          end
          UPD_DR: begin
            case (dr_sel)
              DR_ACC: begin
                // A done on this same clk frees the slot, so the new scan is accepted.
                if (!busy || done) begin
                  rnw    <= dr_sr[0];
                  addr32 <= dr_sr[2:1];
                  dwrite <= dr_sr[34:3];
                  apndp  <= (ir == IR_APACC);
                  req    <= 1'b1;
                  busy   <= 1'b1;
                end
              end
`ifdef JTAG_DP_ABORT_EN
              DR_ABORT: begin
                if (dr_sr[3]) begin
                  busy   <= 1'b0;
                  result <= RESULT_RST;
                end
              end
`endif
              default: ;
            endcase
          end
          default: ;
        endcase
        if (tap_next(state, tms_s) == TLR) ir <= IR_IDCODE;
      end else if (fall) begin
        if (state == SHIFT_DR)      tdo <= dr_sr[0];
        else if (state == SHIFT_IR) tdo <= ir_sr[0];
        else                        tdo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_dp_responder.sv
// Scoreboarded bench for jtag_dp_responder: directed scans plus randomized IR/DR/done traffic.
module tb_jtag_dp_responder;

  logic        clk = 1'b0, rst = 1'b0, tck = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic        done = 1'b0, fault = 1'b0;
  logic [31:0] dread = '0;
  logic        tdo, req, rnw, apndp, busy;
  logic [1:0]  addr32;
  logic [31:0] dwrite;

  always #5 clk = ~clk;

  jtag_dp_responder dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .req(req), .rnw(rnw), .apndp(apndp), .addr32(addr32), .dwrite(dwrite),
    .done(done), .fault(fault), .dread(dread), .busy(busy)
  );

  typedef struct packed {
    logic        rnw;
    logic        apndp;
    logic [1:0]  addr;
    logic [31:0] data;
  } acc_t;

  localparam logic [31:0] IDCODE_VAL = 32'h4BA00477;

  int          n_checks = 0, n_fail = 0;
  acc_t        exp_req_q[$];
  logic [63:0] exp_scan_q[$], act_scan_q[$];
  acc_t        exp_acc;

  // Reference model of the DP as seen from the JTAG pins.
  logic [3:0]  m_ir;
  logic        m_busy;
  logic [34:0] m_result;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_dr_len(input logic [3:0] ir);
    case (ir)
      4'b1010, 4'b1011: return 35;
      4'b1110:          return 32;
`ifdef JTAG_DP_ABORT_EN
      4'b1000:          return 35;
`endif
      default:          return 1;
    endcase
  endfunction

  // Register viewed as a FIFO of bits: captured bits leave first, shifted-in bits queue behind.
  task automatic model_scan(input logic [63:0] cap, input int len, input logic [63:0] din,
                            input int n, output logic [63:0] dout, output logic [63:0] reg_v);
    bit q[$];
    for (int i = 0; i < len; i++) q.push_back(cap[i]);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = q.pop_front();
      q.push_back(din[i]);
    end
    reg_v = '0;
    for (int i = 0; i < len; i++) reg_v[i] = q[i];
  endtask

  // Monitor: checks every req against the scoreboard and every completed scan-out.
  always @(negedge clk) begin
    if (req) begin
      if (exp_req_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got rnw=%0b apndp=%0b addr=%0d data=%0h, expected none",
                 rnw, apndp, addr32, dwrite);
      end else begin
        exp_acc = exp_req_q.pop_front();
        check("req_fields", {28'h0, rnw, apndp, addr32, dwrite}, {28'h0, exp_acc});
      end
    end
    if (act_scan_q.size() > 0 && exp_scan_q.size() > 0)
      check("scan_out", act_scan_q.pop_front(), exp_scan_q.pop_front());
  end

  task automatic jclk(input logic m, input logic d, output logic o);
    @(negedge clk);
    tms = m;
    tdi = d;
    repeat (4) @(negedge clk);
    o   = tdo;
    tck = 1'b1;
    repeat (4) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic model_reset();
    m_ir     = 4'b1110;
    m_busy   = 1'b0;
    m_result = {32'h0, 3'b010};
  endtask

  task automatic tap_reset();
    logic o;
    repeat (5) jclk(1'b1, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    m_ir = 4'b1110;
  endtask

  // Starts and ends in Run-Test/Idle.
  task automatic do_ir(input int n, input logic [63:0] din);
    logic [63:0] e_out, reg_v, a_out;
    logic o;
    model_scan(64'h1, 4, din, n, e_out, reg_v);
    m_ir = reg_v[3:0];
    exp_scan_q.push_back(e_out);
    jclk(1'b1, 1'b0, o);
    jclk(1'b1, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    a_out = '0;
    for (int i = 0; i < n; i++) begin
      jclk(i == n - 1, din[i], o);
      a_out[i] = o;
    end
    jclk(1'b1, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    act_scan_q.push_back(a_out);
  endtask

  task automatic do_dr(input int n, input logic [63:0] din, output logic [63:0] a_out);
    logic [63:0] cap, e_out, reg_v;
    int   len;
    logic is_acc;
    logic o;
    len    = m_dr_len(m_ir);
    is_acc = (m_ir == 4'b1010) || (m_ir == 4'b1011);
    if (is_acc)               cap = m_busy ? 64'h1 : {29'h0, m_result};
    else if (m_ir == 4'b1110) cap = {32'h0, IDCODE_VAL};
    else                      cap = '0;
    model_scan(cap, len, din, n, e_out, reg_v);
    exp_scan_q.push_back(e_out);
    if (is_acc && !m_busy) begin
      exp_req_q.push_back('{rnw: reg_v[0], apndp: (m_ir == 4'b1011), addr: reg_v[2:1],
                            data: reg_v[34:3]});
      m_busy = 1'b1;
    end
`ifdef JTAG_DP_ABORT_EN
    if (m_ir == 4'b1000 && reg_v[3]) begin
      m_busy   = 1'b0;
      m_result = {32'h0, 3'b010};
    end
`endif
    jclk(1'b1, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    a_out = '0;
    for (int i = 0; i < n; i++) begin
      jclk(i == n - 1, din[i], o);
      a_out[i] = o;
    end
    jclk(1'b1, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    act_scan_q.push_back(a_out);
    check("busy_after_dr", {63'h0, busy}, {63'h0, m_busy});
  endtask

  task automatic do_done(input logic [31:0] d, input logic f);
    @(negedge clk);
    done  = 1'b1;
    dread = d;
    fault = f;
    @(negedge clk);
    done = 1'b0;
    if (m_busy) begin
      m_result = {d, 3'b010};
      m_busy   = 1'b0;
    end
    check("busy_after_done", {63'h0, busy}, {63'h0, m_busy});
  endtask

  initial begin
    logic [63:0] o64;
    logic        o;
    int          n;

    // Reset held for two clocks.
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_tdo", {63'h0, tdo}, 64'h1);
    check("reset_outs", {28'h0, req, busy, rnw, apndp, addr32, dwrite}, 64'h0);
    rst = 1'b1;

    // IDCODE after five tms=1 clocks.
    tap_reset();
    do_dr(32, {$urandom, $urandom}, o64);
    check("idcode", o64[31:0], {32'h0, IDCODE_VAL});

    // BYPASS delays tdi by one tck with a 0 capture bit.
    do_ir(4, 64'hF);
    do_dr(8, 64'hB2, o64);
    check("bypass", o64[7:0], 64'h64);

    // DPACC write.
    do_ir(4, 64'hA);
    do_dr(35, {29'h0, 32'hDEADBEEF, 2'b01, 1'b0}, o64);
    check("dpacc_write_busy", {63'h0, busy}, 64'h1);

    // WAIT while busy, then a completed read result.
    do_dr(35, 64'h1, o64);
    check("wait_ack", o64[2:0], 64'h1);
    do_done(32'h12345678, 1'b0);
    do_dr(35, 64'h3, o64);
    check("ok_ack", o64[2:0], 64'h2);
    check("read_data", o64[34:3], 64'h12345678);
    do_done($urandom, 1'b1);

    // Reset while busy and in Shift-DR.
    do_dr(35, {$urandom, $urandom}, o64);
    jclk(1'b1, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    jclk(1'b0, 1'b0, o);
    repeat (3) jclk(1'b0, 1'b1, o);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", {63'h0, busy}, 64'h0);
    check("midreset_tdo", {63'h0, tdo}, 64'h1);
    rst = 1'b1;
    exp_scan_q.push_back('0);
    act_scan_q.push_back('0);
    model_reset();
    do_done(32'hCAFEF00D, 1'b0);
    jclk(1'b0, 1'b0, o);
    do_dr(32, '0, o64);
    check("midreset_ir_idcode", o64[31:0], {32'h0, IDCODE_VAL});
    do_ir(4, 64'hA);
    do_dr(35, 64'h1, o64);
    check("midreset_result", o64[34:0], 64'h2);
    do_done($urandom, 1'b0);

`ifdef JTAG_DP_ABORT_EN
    do_dr(35, {$urandom, $urandom}, o64);
    do_ir(4, 64'h8);
    do_dr(35, 64'h8, o64);
    check("abort_busy", {63'h0, busy}, 64'h0);
    do_ir(4, 64'hA);
    do_dr(35, 64'h1, o64);
    check("abort_ack", o64[2:0], 64'h2);
    do_done($urandom, 1'b0);
`endif

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          logic [3:0] irv;
          case ($urandom_range(0, 5))
            0:       irv = 4'b1010;
            1:       irv = 4'b1011;
            2:       irv = 4'b1110;
            3:       irv = 4'b1111;
            4:       irv = 4'b1000;
            default: irv = 4'($urandom);
          endcase
          do_ir(($urandom_range(0, 9) == 0) ? 5 : 4, {$urandom, 28'h0, irv});
        end
        2, 3, 4, 5, 6: begin
          n = ($urandom_range(0, 9) < 6) ? m_dr_len(m_ir) : $urandom_range(1, 40);
          do_dr(n, {$urandom, $urandom}, o64);
        end
        7, 8: do_done($urandom, 1'($urandom));
        default: tap_reset();
      endcase
    end

    repeat (5) @(negedge clk);
    check("pending_req", 64'(exp_req_q.size()), 64'h0);
    check("pending_scan", 64'(exp_scan_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_dp_responder.md
Name: jtag_dp_responder

Overview:
- Target-side JTAG-DP responder: the TAP that a JTAG initiator drives.
- Oversamples tck/tms/tdi in the system clock domain and runs the 16-state IEEE 1149.1 TAP controller.
- Implements the IDCODE, BYPASS, DPACC and APACC registers.
- Hands each completed DPACC/APACC scan to an upstream DP/AP model through a req/done handshake; used as a loopback target in benches and on hardware.

Parameters:
- IDCODE_VAL, 32'h4BA00477, value shifted out by the IDCODE instruction.
- SYNC_STAGES, 2, synchroniser depth on tck/tms/tdi; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 4x the tck frequency.
- rst  in  1  synchronous, active-low reset.
- tck  in  1  JTAG clock from the initiator (asynchronous).
- tms  in  1  test mode select.
- tdi  in  1  test data in.
- tdo  out 1  test data out.
- req  out 1  access request pulse, 1 clk wide.
- rnw  out 1  read(1)/write(0), valid with req.
- apndp out 1  AP(1)/DP(0), valid with req.
- addr32 out 2  address bits 3:2, valid with req.
- dwrite out 32  write data, valid with req.
- done  in 1  upstream access complete, 1 clk pulse.
- fault in 1  upstream fault flag, sampled with done.
- dread in 32  upstream read data, sampled with done.
- busy out 1  access outstanding.

Behaviour:
Reset (rst==0 at a clk edge), all of the following take effect on that edge:
- TAP state = Test-Logic-Reset; IR = IDCODE (4'b1110).
- tdo=1; req=0; busy=0; rnw=0; apndp=0; addr32=0; dwrite=0.
- Stored result = {32'h0, 3'b010}.
- An outstanding access is abandoned; a done arriving after reset is ignored.

Sampling:
- tck, tms and tdi each pass through SYNC_STAGES flops.
- Edge detect is on the synchronised tck.
- Rising edge: use the synchronised tms/tdi from the same stage; advance the TAP, shift the selected register, then update.
- Falling edge: tdo <= LSB of the active shift register.
- In any state other than Shift-IR/Shift-DR, tdo holds 1.
- Latency: tdo changes SYNC_STAGES+1 clk after the tck falling edge.

TAP state machine:
- Standard 16 states with standard tms transitions.
- From any state, five tms=1 rising edges reach Test-Logic-Reset.
- Entering Test-Logic-Reset forces IR = IDCODE.

IR handling:
- 4 bits, shifted LSB first.
- Capture-IR loads 4'b0001.
- Update-IR latches the shifted value.
- Decode: 4'b1010 DPACC, 4'b1011 APACC, 4'b1110 IDCODE, 4'b1111 BYPASS.
- Any other value selects BYPASS.

DR lengths:
- IDCODE: 32 bits; Capture-DR loads IDCODE_VAL.
- BYPASS: 1 bit; Capture-DR loads 0.
- DPACC/APACC: 35 bits, shifted LSB first.

DPACC/APACC field layout:
- Shift-in: bit0 = RnW, bits2:1 = addr32, bits34:3 = write data.
- Capture when busy==1: load {32'h0, 3'b001} (WAIT).
- Capture when busy==0: load the stored result: {rdata, ack}, ack 3'b010 (OK/FAULT).

Update-DR on DPACC/APACC:
- If busy==0 at Update-DR:
  - Drive rnw/addr32/dwrite/apndp from the shifted value.
  - Pulse req for 1 clk; busy <= 1.
- If busy==1 at Update-DR: the scan is discarded, no req is issued, and busy and the stored result are unchanged.
- When done==1 and busy==1:
  - Stored result <= {dread, 3'b010}; fault is recorded but does not change ack (JTAG-DP reports faults via CTRL/STAT).
  - busy <= 0.
- done while busy==0 is ignored.
- done and a new Update-DR on the same clk: done completes first, so the new request is accepted.

Boundary conditions:
- A shift shorter or longer than the register length is not an error: excess bits fall through to tdo (the register acts as a FIFO toward tdo); Update uses whatever was shifted.
- Simultaneous rising and falling edge detections cannot occur. If the synchronised tck toggles twice within one clk, the second edge is lost; this is prevented by the clk ≥ 4x tck constraint.

Optional Feature:
- Macro: JTAG_DP_ABORT_EN.
- When defined:
  - IR 4'b1000 selects a 35-bit ABORT DR.
  - Capture-DR for ABORT loads 0.
  - Update-DR with shifted data bit3 (DAPABORT) == 1 clears busy, sets stored result = {32'h0, 3'b010}, and issues no req.
- When not defined: IR 4'b1000 selects BYPASS.

Test Plan:
- Post-reset IDCODE: rst low 2 clk, then tms=1 x5, go to Shift-DR, clock 32 bits -> tdo stream LSB-first equals 32'h4BA00477.
- BYPASS: IR=4'b1111, shift tdi pattern 8'b10110010 through Shift-DR -> tdo equals the pattern delayed by 1 tck; Capture bit = 0.
- DPACC write: IR=4'b1010, shift {32'hDEADBEEF, addr32=2'b01, RnW=0} -> req pulse with dwrite=32'hDEADBEEF, addr32=1, rnw=0, apndp=0; busy=1.
- WAIT, then read: with busy=1, next DPACC Capture -> ack bits 3'b001 and no req. Then done with dread=32'h12345678 and rescan -> ack 3'b010 and data 32'h12345678.
- Reset mid-access: assert rst while busy=1 and in Shift-DR -> next clk: busy=0, tdo=1, TAP in Test-Logic-Reset, IR=IDCODE; a later done is ignored.
- ABORT (JTAG_DP_ABORT_EN defined): busy=1, IR=4'b1000, shift DAPABORT=1, Update-DR -> busy=0, no req; next DPACC Capture ack = 3'b010.
